// File: rtl/mux_logic_reducer_pkg.sv
// mux_reducer_pkg: shared types and elaboration helpers for the mux-only
// reduction unit (mux_logic_reducer and its tree node).
package mux_reducer_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'd0,
      OP_OR  = 2'd1,
      OP_XOR = 2'd2,
      OP_NOR = 2'd3
   } op_e;

   // Padding value that leaves the reduction unchanged; NOR pads like OR
   // because its tree is an OR tree inverted at the output.
   function automatic logic identity(op_e op);
      return (op == OP_AND);
   endfunction

   // ceil(log2(width)) for width >= 2
   function automatic int unsigned levels(int unsigned width);
      int unsigned l;
      l = 0;
      for (int unsigned p = 1; p < width; p = p * 2) begin
         l = l + 1;
      end
      return l;
   endfunction

   // Number of register ranks when lps tree levels sit between registers
   function automatic int unsigned stages(int unsigned width, int unsigned lps);
      return (levels(width) + lps - 1) / lps;
   endfunction

endpackage

// File: rtl/mux_logic_reducer_if.sv
// mux_logic_reducer_if: upstream/downstream valid-ready handshake bundle.
// master = producer/consumer side, slave = reduction unit side.
interface mux_logic_reducer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             up_valid;
   logic             up_ready;
   logic [WIDTH-1:0] up_data;
   logic [1:0]       up_op;
   logic             down_valid;
   logic             down_ready;
   logic             down_data;

   modport master (
      output up_valid, up_data, up_op, down_ready,
      input  up_ready, down_valid, down_data
   );

   modport slave (
      input  up_valid, up_data, up_op, down_ready,
      output up_ready, down_valid, down_data
   );
endinterface

// File: rtl/mux_logic_reducer_node.sv
// mux: the 2:1 primitive every gate in this unit is built from.
// mux_reduce_node: one op-selectable reduction node (AND/OR/XOR, NOR uses OR)
// composed purely of mux instances and constants.
module mux (
   input  logic i_sel,
   input  logic i_d0,
   input  logic i_d1,
   output logic o_y
);
   assign o_y = i_sel ? i_d1 : i_d0;
endmodule

module mux_reduce_node
   import mux_reducer_pkg::*;
(
   input  logic a,
   input  logic b,
   input  op_e  op,
   output logic y
);
   logic [1:0] w_op;
   logic       w_nb;
   logic       w_and;
   logic       w_or;
   logic       w_xor;
   logic       w_m0;
   logic       w_m1;

   assign w_op = op;

   // !b
   mux u_nb  (.i_sel(b),       .i_d0(1'b1),  .i_d1(1'b0), .o_y(w_nb));
   // a ? b : 0
   mux u_and (.i_sel(a),       .i_d0(1'b0),  .i_d1(b),    .o_y(w_and));
   // a ? 1 : b
   mux u_or  (.i_sel(a),       .i_d0(b),     .i_d1(1'b1), .o_y(w_or));
   // a ? !b : b
   mux u_xor (.i_sel(a),       .i_d0(b),     .i_d1(w_nb), .o_y(w_xor));
   // op[0] picks OR over AND (ops 0/1) and OR over XOR (ops 2/3, NOR = OR tree)
   mux u_m0  (.i_sel(w_op[0]), .i_d0(w_and), .i_d1(w_or), .o_y(w_m0));
   mux u_m1  (.i_sel(w_op[0]), .i_d0(w_xor), .i_d1(w_or), .o_y(w_m1));
   mux u_y   (.i_sel(w_op[1]), .i_d0(w_m0),  .i_d1(w_m1), .o_y(y));
endmodule

// File: rtl/mux_logic_reducer.sv
// mux_logic_reducer: pipelined WIDTH-to-1 reduction (AND/OR/XOR/NOR) built
// from mux_reduce_node trees, LEVELS_PER_STAGE tree levels per register rank.
// The whole pipeline advances in lockstep, so each word keeps its own op.
// Optional: define MUX_REDUCER_SKID_EN to add a 1-entry output skid buffer,
// which makes up_ready a register with no path from down_ready.
module mux_logic_reducer
   import mux_reducer_pkg::*;
#(
   parameter int unsigned WIDTH            = 8,
   parameter int unsigned LEVELS_PER_STAGE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux_logic_reducer_if.slave    bus
);
   localparam int unsigned LEVELS = levels(WIDTH);
   localparam int unsigned NPAD   = 1 << LEVELS;
   localparam int unsigned STAGES = stages(WIDTH, LEVELS_PER_STAGE);

   logic              w_adv;
   op_e               w_up_op;
   logic [NPAD-1:0]   w_pad;
   op_e               w_stg_op [STAGES];
   logic [STAGES-1:0] r_vld;
   op_e               r_op [STAGES];
   logic              w_root;
   logic              w_root_n;
   logic              w_is_nor;
   logic              w_last_vld;
   logic              w_last_dat;

   assign w_up_op = op_e'(bus.up_op);

   // Pad to a power of two with the op's identity element
   for (genvar i = 0; i < NPAD; i++) begin : g_pad
      if (i < WIDTH) begin : g_data
         assign w_pad[i] = bus.up_data[i];
      end else begin : g_fill
         assign w_pad[i] = identity(w_up_op);
      end
   end

   // Op seen by the tree levels of each stage: stage 0 works on the incoming
   // word, later stages on the op registered alongside their data.
   always_comb begin
      w_stg_op = '{default: OP_AND};
      w_stg_op[0] = w_up_op;
      for (int unsigned s = 1; s < STAGES; s++) begin
         w_stg_op[s] = r_op[s-1];
      end
   end

   // Valid and op travel with their word; everything shifts only on advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int unsigned s = 0; s < STAGES; s++) begin
            r_op[s] <= OP_AND;
         end
      end else if (w_adv) begin
         r_vld[0] <= bus.up_valid;
         r_op[0]  <= w_up_op;
         for (int unsigned s = 1; s < STAGES; s++) begin
            r_vld[s] <= r_vld[s-1];
            r_op[s]  <= r_op[s-1];
         end
      end
   end

   // Reduction tree: level l halves the previous level; a register rank
   // closes every LEVELS_PER_STAGE levels and always after the root.
   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int unsigned NN  = NPAD >> l;
      localparam int unsigned STG = (l - 1) / LEVELS_PER_STAGE;

      logic [2*NN-1:0] w_in;
      logic [NN-1:0]   w_y;
      logic [NN-1:0]   w_out;

      if (l == 1) begin : g_first
         assign w_in = w_pad;
      end else begin : g_next
         assign w_in = g_lvl[l-1].w_out;
      end

      for (genvar k = 0; k < NN; k++) begin : g_node
         mux_reduce_node u_node (
            .a  (w_in[2*k]),
            .b  (w_in[2*k+1]),
            .op (w_stg_op[STG]),
            .y  (w_y[k])
         );
      end

      if ((l % LEVELS_PER_STAGE == 0) || (l == LEVELS)) begin : g_reg
         logic [NN-1:0] r_dat;

         // Capture this stage's partial results; hold while stalled
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_dat <= '0;
            end else if (w_adv) begin
               r_dat <= w_y;
            end
         end

         assign w_out = r_dat;
      end else begin : g_comb
         assign w_out = w_y;
      end
   end

   assign w_root     = g_lvl[LEVELS].w_out[0];
   assign w_is_nor   = (r_op[STAGES-1] == OP_NOR);
   assign w_last_vld = r_vld[STAGES-1];

   // NOR is the OR tree result inverted by one mux after the last rank
   mux u_inv (.i_sel(w_root),   .i_d0(1'b1),   .i_d1(1'b0),     .o_y(w_root_n));
   mux u_nor (.i_sel(w_is_nor), .i_d0(w_root), .i_d1(w_root_n), .o_y(w_last_dat));

`ifdef MUX_REDUCER_SKID_EN
   logic r_skid_vld;
   logic r_skid_dat;

   // Skid slot catches the last-rank word when the consumer stalls; the
   // pipeline only moves while the slot is empty, so nothing is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skid_vld <= 1'b0;
         r_skid_dat <= 1'b0;
      end else if (r_skid_vld) begin
         if (bus.down_ready) begin
            r_skid_vld <= 1'b0;
         end
      end else if (w_last_vld && !bus.down_ready) begin
         r_skid_vld <= 1'b1;
         r_skid_dat <= w_last_dat;
      end
   end

   assign w_adv          = !r_skid_vld;
   assign bus.down_valid = r_skid_vld | w_last_vld;
   assign bus.down_data  = r_skid_vld ? r_skid_dat : w_last_dat;
`else
   assign w_adv          = !(w_last_vld && !bus.down_ready);
   assign bus.down_valid = w_last_vld;
   assign bus.down_data  = w_last_dat;
`endif

   assign bus.up_ready = w_adv;

endmodule

// File: doc/mux_logic_reducer.md
# mux_logic_reducer

Parametrised, pipelined reduction unit that collapses a WIDTH-bit word to one bit under a per-transaction operation (AND, OR, XOR, NOR). It is built only from 2:1 `mux` primitives, constants and pipeline registers. It generalises single-gate-from-mux logic to N-input, op-selectable, handshaked datapaths. It sits between a valid/ready producer and consumer in the combinational-logic exercise chain.

## Interface
- `WIDTH`, 8: input word width; ≥2, need not be a power of two.
- `LEVELS_PER_STAGE`, 1: tree levels between pipeline registers; ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `up_valid`  in  1  input word valid.
- `up_ready`  out  1  unit accepts input this cycle.
- `up_data`  in  WIDTH  word to reduce.
- `up_op`  in  2  operation: 0 AND, 1 OR, 2 XOR, 3 NOR.
- `down_valid`  out  1  result valid.
- `down_ready`  in  1  consumer accepts result.
- `down_data`  out  1  reduction result.

## Operation
- LEVELS = clog2(WIDTH); STAGES = ceil(LEVELS / LEVELS_PER_STAGE).
- Pad the input to 2^LEVELS with the identity element: 1 for AND, 0 for OR/XOR/NOR.
- Tree node per op, muxes only:
  - AND: a ? b : 0
  - OR: a ? 1 : b
  - XOR: a ? (b ? 0 : 1) : b
  - NOR: OR tree, inverted by one mux at the final stage.
- `up_op` travels with its word through every stage; no cross-transaction mixing.
- Transfer occurs on valid && ready at both ports.
- Global advance: adv = !(down_valid && !down_ready).
  - With adv, all stages shift one position, and bubbles shift too.
  - Without adv, every stage holds.
- `up_ready` = adv.
- Reset values: `down_valid`=0, `down_data`=0, `up_ready`=1 once reset is released, and all internal valid bits 0.
- Reset mid-operation discards all in-flight words immediately because reset is asynchronous. No result is produced from pre-reset inputs.

## Timing
- Latency is STAGES cycles from the accepting edge to `down_valid`. For WIDTH=8, LEVELS_PER_STAGE=1, that is 3 cycles.
- Throughput is one word per cycle while `down_ready`=1.
- `down_data` and `down_valid` are stable while stalled (`down_valid`=1, `down_ready`=0).
- Simultaneous accept at both ports in a full pipeline is allowed. The pipeline shifts with no loss.
- Without the skid buffer, `up_ready` depends combinationally on `down_ready`.

## Configuration
- `MUX_REDUCER_SKID_EN` defined: a 1-entry skid buffer is added after the last stage.
  - `up_ready` becomes a register: 1 when the skid buffer is empty.
  - The buffer absorbs one word when `down_ready` drops.
  - Latency is unchanged.
  - No combinational path from `down_ready` to `up_ready`.
- Undefined: no skid buffer; `up_ready` = adv, combinational, as above.

## Structure
- Package `mux_reducer_pkg` contains:
  - `op_e` enum: OP_AND, OP_OR, OP_XOR, OP_NOR.
  - `identity(op_e)` function.
  - `levels(width)` and `stages(width, lps)` functions.
- Sub-module `mux_reduce_node`:
  - Ports: a, b, op → y.
  - Built from existing `mux` instances only.
  - Instantiated in a generate tree.

## Test plan
- WIDTH=8, OR. Input 8'h00 gives 0; 8'h10 gives 1. Each result appears exactly 3 cycles after accept.
- AND. Input 8'hFF gives 1; 8'hFE gives 0.
- Stream of 4 back-to-back words with `down_ready`=1:
  - Inputs: XOR 8'h07, NOR 8'h00, AND 8'h7F, OR 8'h80.
  - Expected outputs 1, 1, 0, 1 on consecutive cycles.
- Pipeline full, `down_ready`=0 for 5 cycles:
  - `up_ready`=0, `down_data` held, no words lost.
  - After release, 3 results drain in order.
- WIDTH=5, LEVELS_PER_STAGE=2 (2 stages):
  - AND 5'b11111 gives 1; NOR 5'b00000 gives 1; XOR 5'b10000 gives 1.
  - Padding is correct and latency is 2.
- `rst_n` pulsed low mid-stream (between edges):
  - `down_valid` goes to 0 immediately.
  - After release, the first result corresponds only to the first post-reset input.
